// File: rtl/divu_sequencer_if.sv
// Handshake/data bundle between the ALU-side requester and divu_sequencer.
//   master: drives in_valid, dividend, divisor, out_ready; receives results.
//   slave : the divider; drives in_ready, out_valid, quotient, remainder,
//           div_by_zero.
interface divu_sequencer_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divu_sequencer.sv
// Multi-cycle unsigned restoring divider controller.
// One N+1-bit compare/subtract datapath is reused for N iterations, retiring
// one quotient bit per cycle. Divide-by-zero short-circuits straight to DONE.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   io   - divu_sequencer_if.slave: in_valid/in_ready + dividend/divisor on
//          the request side, out_valid/out_ready + quotient/remainder/
//          div_by_zero on the response side.
module divu_sequencer #(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst,
  divu_sequencer_if.slave   io
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  count, count_nx;
  logic [N-1:0]   q, q_nx;
  logic [N-1:0]   d, d_nx;
  logic [N:0]     r, r_nx;
  logic           dbz, dbz_nx;

  // Shared datapath: shift in next dividend bit, then S - {0,D} via
  // inverted operand plus carry-in. Carry out clear means a borrow, i.e. S < D.
  logic [N:0]     s;
  logic [N+1:0]   diff;
  logic           lt;

  assign s    = {r[N-1:0], q[N-1]};
  assign diff = {1'b0, s} + {1'b0, ~{1'b0, d}} + {{(N+1){1'b0}}, 1'b1};
  assign lt   = ~diff[N+1];

  // R stays below D, so its top bit is always zero; only used as datapath width.
  logic unused_r_msb;
  assign unused_r_msb = r[N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      q     <= '0;
      d     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      q     <= q_nx;
      d     <= d_nx;
      r     <= r_nx;
      dbz   <= dbz_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    q_nx     = q;
    d_nx     = d;
    r_nx     = r;
    dbz_nx   = dbz;
    case (state)
      IDLE: begin
        if (io.in_valid) begin
          q_nx   = io.dividend;
          d_nx   = io.divisor;
          r_nx   = '0;
          dbz_nx = 1'b0;
          if (io.divisor == '0) begin
            state_nx = DONE;
            q_nx     = '1;
            r_nx     = {1'b0, io.dividend};
            dbz_nx   = 1'b1;
          end else begin
            state_nx = CALC;
            count_nx = CW'(N-1);
          end
        end
      end
      CALC: begin
        r_nx = lt ? s : diff[N:0];
        q_nx = {q[N-2:0], ~lt};
        if (count == '0) state_nx = DONE;
        else             count_nx = count - CW'(1);
      end
      DONE: begin
        if (io.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign io.in_ready    = (state == IDLE);
  assign io.out_valid   = (state == DONE);
  assign io.quotient    = q;
  assign io.remainder   = r[N-1:0];
  assign io.div_by_zero = dbz;
endmodule
